// File: rtl/bench_mc_bounded_monitor_if.sv
// Request/grant/response bundle for the N-channel bounded monitor.
// The master drives requests, grants and responses; the slave (the monitor)
// returns the sticky error, the real-time request event and the counters.
interface bench_mc_bounded_monitor_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 3
);
  logic [N_CH-1:0]       i;
  logic [N_CH-1:0]       controllable_i;
  logic [N_CH-1:0]       response;
  logic                  error;
  logic                  _rt_get;
  logic [N_CH*CNT_W-1:0] resp_cnt;

  modport master (
    output i,
    output controllable_i,
    output response,
    input  error,
    input  _rt_get,
    input  resp_cnt
  );

  modport slave (
    input  i,
    input  controllable_i,
    input  response,
    output error,
    output _rt_get,
    output resp_cnt
  );
endinterface

// File: rtl/bench_mc_bounded_monitor.sv
// N-channel request/grant/response monitor.
// Each channel walks IDLE -> PEND -> SERV. The monitor bounds how long a
// request may wait for a grant, refuses grants to channels whose response
// count already exceeds BOUND, and optionally forbids simultaneous grants.
// Any violation sets a sticky error that only rst clears.
module bench_mc_bounded_monitor #(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 3,
  parameter int BOUND       = 2,
  parameter int MAX_WAIT    = 3,
  parameter int ALLOW_MULTI = 0
) (
  input  logic clk,
  input  logic rst,
  bench_mc_bounded_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SERV = 2'd2
  } ch_state_t;

  // Timer threshold: reaching MAX_WAIT is the violation, so the check is
  // done on the pre-increment value to avoid wrapping when MAX_WAIT is the
  // largest value the timer can hold.
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] BOUND_CNT  = CNT_W'(BOUND);
  localparam bit               MUTEX_ON   = (ALLOW_MULTI == 0) && (N_CH > 1);

  ch_state_t        state      [N_CH];
  ch_state_t        state_nxt  [N_CH];
  logic [CNT_W-1:0] timer      [N_CH];
  logic [CNT_W-1:0] timer_nxt  [N_CH];
  logic [CNT_W-1:0] cnt        [N_CH];
  logic [CNT_W-1:0] cnt_nxt    [N_CH];

  logic [N_CH-1:0]  viol_timeout;
  logic [N_CH-1:0]  viol_bound;
  logic [N_CH-1:0]  grant_pend;
  logic             grant_seen;
  logic             grant_multi;
  logic             viol_any;
  logic             error_q;

  // Saturating increment for the response counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Next-state, timer, counter and violation detection for every channel.
  always_comb begin
    viol_timeout = '0;
    viol_bound   = '0;
    grant_pend   = '0;
    grant_seen   = 1'b0;
    grant_multi  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      state_nxt[c] = state[c];
      timer_nxt[c] = timer[c];
      cnt_nxt[c]   = cnt[c];
      case (state[c])
        ST_IDLE: begin
          if (bus.i[c]) begin
            state_nxt[c] = ST_PEND;
            timer_nxt[c] = '0;
          end
        end
        ST_PEND: begin
          if (bus.controllable_i[c]) begin
            grant_pend[c] = 1'b1;
            state_nxt[c]  = ST_SERV;
            if (cnt[c] > BOUND_CNT) begin
              viol_bound[c] = 1'b1;
            end
          end else if (timer[c] >= WAIT_LAST) begin
            // Keep flagging while the request stays starved; hold the timer.
            viol_timeout[c] = 1'b1;
            timer_nxt[c]    = WAIT_LIMIT;
          end else begin
            timer_nxt[c] = timer[c] + 1'b1;
          end
        end
        ST_SERV: begin
          if (bus.response[c]) begin
            cnt_nxt[c] = sat_inc(cnt[c]);
            if (bus.i[c]) begin
              state_nxt[c] = ST_PEND;
              timer_nxt[c] = '0;
            end else begin
              state_nxt[c] = ST_IDLE;
            end
          end
        end
        default: begin
          state_nxt[c] = ST_IDLE;
          timer_nxt[c] = '0;
        end
      endcase
    end
    // More than one grant landing on pending channels in the same cycle.
    for (int c = 0; c < N_CH; c++) begin
      if (grant_pend[c]) begin
        if (grant_seen) begin
          grant_multi = 1'b1;
        end
        grant_seen = 1'b1;
      end
    end
    viol_any = (|viol_timeout) || (|viol_bound) || (MUTEX_ON && grant_multi);
  end

  // State, timers, counters and sticky error; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        state[c] <= ST_IDLE;
        timer[c] <= '0;
        cnt[c]   <= '0;
      end
      error_q <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        state[c] <= state_nxt[c];
        timer[c] <= timer_nxt[c];
        cnt[c]   <= cnt_nxt[c];
      end
      if (viol_any) begin
        error_q <= 1'b1;
      end
    end
  end

  // Counters are exported packed, channel 0 in the least significant bits.
  for (genvar c = 0; c < N_CH; c++) begin : g_pack
    assign bus.resp_cnt[c*CNT_W +: CNT_W] = cnt[c];
  end

  assign bus.error   = error_q;
  assign bus._rt_get = |bus.i;

endmodule

// File: tb/tb_bench_mc_bounded_monitor.sv
// Bench for bench_mc_bounded_monitor: two instances (mutex enforced and
// simultaneous grants allowed) share one stimulus stream and are compared
// every cycle against a per-channel behavioural model.
module tb_bench_mc_bounded_monitor;

  localparam int N_CH     = 2;
  localparam int CNT_W    = 3;
  localparam int BOUND    = 2;
  localparam int MAX_WAIT = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_CH-1:0] drv_i    = '0;
  logic [N_CH-1:0] drv_g    = '0;
  logic [N_CH-1:0] drv_r    = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Model: index 0 = ALLOW_MULTI 0 instance, index 1 = ALLOW_MULTI 1 instance.
  bit m_waiting [2][N_CH];
  bit m_serving [2][N_CH];
  int m_waited  [2][N_CH];
  int m_served  [2][N_CH];
  bit m_err     [2];

  always #5 clk = ~clk;

  bench_mc_bounded_monitor_if #(.N_CH(N_CH), .CNT_W(CNT_W)) ifa ();
  bench_mc_bounded_monitor_if #(.N_CH(N_CH), .CNT_W(CNT_W)) ifb ();

  assign ifa.i              = drv_i;
  assign ifa.controllable_i = drv_g;
  assign ifa.response       = drv_r;
  assign ifb.i              = drv_i;
  assign ifb.controllable_i = drv_g;
  assign ifb.response       = drv_r;

  bench_mc_bounded_monitor #(
    .N_CH(N_CH), .CNT_W(CNT_W), .BOUND(BOUND), .MAX_WAIT(MAX_WAIT), .ALLOW_MULTI(0)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ifa.slave)
  );

  bench_mc_bounded_monitor #(
    .N_CH(N_CH), .CNT_W(CNT_W), .BOUND(BOUND), .MAX_WAIT(MAX_WAIT), .ALLOW_MULTI(1)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the reference by one clock using the inputs currently driven.
  task automatic model_clock();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int c = 0; c < N_CH; c++) begin
          m_waiting[m][c] = 0;
          m_serving[m][c] = 0;
          m_waited[m][c]  = 0;
          m_served[m][c]  = 0;
        end
        m_err[m] = 0;
      end else begin
        int granted_waiters;
        bit bad;
        granted_waiters = 0;
        bad = 0;
        for (int c = 0; c < N_CH; c++)
          if (m_waiting[m][c] && drv_g[c]) granted_waiters++;
        if (m == 0 && granted_waiters > 1) bad = 1;
        for (int c = 0; c < N_CH; c++) begin
          if (m_waiting[m][c]) begin
            if (drv_g[c]) begin
              if (m_served[m][c] > BOUND) bad = 1;
              m_waiting[m][c] = 0;
              m_serving[m][c] = 1;
            end else begin
              m_waited[m][c]++;
              if (m_waited[m][c] >= MAX_WAIT) begin
                bad = 1;
                m_waited[m][c] = MAX_WAIT;
              end
            end
          end else if (m_serving[m][c]) begin
            if (drv_r[c]) begin
              m_served[m][c] = (m_served[m][c] < CNT_MAX) ? m_served[m][c] + 1 : CNT_MAX;
              m_serving[m][c] = 0;
              if (drv_i[c]) begin
                m_waiting[m][c] = 1;
                m_waited[m][c]  = 0;
              end
            end
          end else if (drv_i[c]) begin
            m_waiting[m][c] = 1;
            m_waited[m][c]  = 0;
          end
        end
        if (bad) m_err[m] = 1;
      end
    end
  endtask

  function automatic logic [N_CH*CNT_W-1:0] model_cnt(input int m);
    logic [N_CH*CNT_W-1:0] v;
    v = '0;
    for (int c = 0; c < N_CH; c++) v[c*CNT_W +: CNT_W] = CNT_W'(m_served[m][c]);
    return v;
  endfunction

  // One clock: drive on negedge, check the combinational event, clock the
  // model at posedge and compare registered outputs just after it.
  task automatic cycle(input logic [N_CH-1:0] ii, input logic [N_CH-1:0] gg,
                       input logic [N_CH-1:0] rr);
    @(negedge clk);
    drv_i = ii;
    drv_g = gg;
    drv_r = rr;
    #1;
    chk("rt_get_a", 32'(ifa._rt_get), 32'(|ii));
    chk("rt_get_b", 32'(ifb._rt_get), 32'(|ii));
    @(posedge clk);
    model_clock();
    #1;
    chk("error_a", 32'(ifa.error), 32'(m_err[0]));
    chk("error_b", 32'(ifb.error), 32'(m_err[1]));
    chk("cnt_a", 32'(ifa.resp_cnt), 32'(model_cnt(0)));
    chk("cnt_b", 32'(ifb.resp_cnt), 32'(model_cnt(1)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(2'b00, 2'b00, 2'b00);
    rst = 1'b0;
  endtask

  task automatic serve_ch0();
    cycle(2'b01, 2'b00, 2'b00);
    cycle(2'b00, 2'b01, 2'b00);
    cycle(2'b00, 2'b00, 2'b01);
  endtask

  initial begin
    // Reset with random activity on the inputs.
    rst = 1'b1;
    for (int k = 0; k < 2; k++)
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    chk("reset_error", 32'(ifa.error), 32'd0);
    chk("reset_cnt", 32'(ifa.resp_cnt), 32'd0);
    rst = 1'b0;

    // Normal service on channel 0.
    do_reset();
    cycle(2'b01, 2'b00, 2'b00);
    cycle(2'b00, 2'b01, 2'b00);
    cycle(2'b00, 2'b00, 2'b00);
    cycle(2'b00, 2'b00, 2'b01);
    chk("service_cnt0", 32'(ifa.resp_cnt[CNT_W-1:0]), 32'd1);
    chk("service_error", 32'(ifa.error), 32'd0);

    // Starved request on channel 1.
    do_reset();
    cycle(2'b10, 2'b00, 2'b00);
    cycle(2'b00, 2'b00, 2'b00);
    cycle(2'b00, 2'b00, 2'b00);
    chk("timeout_early", 32'(ifa.error), 32'd0);
    cycle(2'b00, 2'b00, 2'b00);
    chk("timeout_hit", 32'(ifa.error), 32'd1);
    for (int k = 0; k < 16; k++) cycle(2'b00, 2'b00, 2'b00);
    chk("timeout_sticky", 32'(ifa.error), 32'd1);

    // Grant after the response bound is used up.
    do_reset();
    for (int k = 0; k < 3; k++) serve_ch0();
    chk("bound_before", 32'(ifa.error), 32'd0);
    cycle(2'b01, 2'b00, 2'b00);
    cycle(2'b00, 2'b01, 2'b00);
    chk("bound_hit", 32'(ifa.error), 32'd1);

    // Simultaneous grants to two pending channels.
    do_reset();
    cycle(2'b11, 2'b00, 2'b00);
    cycle(2'b00, 2'b11, 2'b00);
    chk("mutex_strict", 32'(ifa.error), 32'd1);
    chk("mutex_allowed", 32'(ifb.error), 32'd0);

    // Counter saturation, then reset while serving.
    do_reset();
    for (int k = 0; k < 9; k++) serve_ch0();
    chk("sat_cnt0", 32'(ifa.resp_cnt[CNT_W-1:0]), 32'd7);
    cycle(2'b01, 2'b00, 2'b00);
    cycle(2'b00, 2'b01, 2'b00);
    rst = 1'b1;
    cycle(2'b00, 2'b00, 2'b01);
    rst = 1'b0;
    chk("midrst_cnt", 32'(ifa.resp_cnt), 32'd0);
    chk("midrst_error", 32'(ifa.error), 32'd0);
    cycle(2'b00, 2'b01, 2'b01);
    chk("midrst_idle", 32'(ifa.resp_cnt), 32'd0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
